glyph_line_renderer: RTL and testbench

- Sequential text-line renderer for the VGA text overlay. It holds a writable buffer of NUM_CHARS glyph IDs and walks the raster with pixel/line counters instead of per-pixel division.
- It produces a registered 1-bit "pixel on" per active pixel for a line of 5x5-cell glyphs scaled by SCALE.
- It sits between the VGA timing generator (x, y, pix_en) and the colour mux. It replaces per-letter combinational rectangle decoding.

---
 rtl/glyph_pkg.sv | 48 ++++
 rtl/glyph_rom.sv | 23 ++
 rtl/glyph_line_renderer.sv | 212 +++++++++++++++++++++
 tb/tb_glyph_line_renderer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// glyph_pkg: glyph IDs, 5x5 bitmap type and the bitmap table shared by the text renderer.
package glyph_pkg;

    localparam int GLYPH_CELLS      = 5;
    localparam int BLANK_ID_DEFAULT = 63;
    localparam int BLINK_PERIOD     = 32;

    localparam int ID_P       = 0;
    localparam int ID_L       = 1;
    localparam int ID_A       = 2;
    localparam int ID_Y       = 3;
    localparam int ID_E       = 4;
    localparam int ID_V       = 5;
    localparam int ID_W       = 6;
    localparam int ID_H       = 7;
    localparam int ID_C       = 8;
    localparam int ID_M       = 9;
    localparam int ID_O       = 10;
    localparam int ID_DASH    = 11;
    localparam int ID_DIGIT_1 = 12;
    localparam int ID_DIGIT_2 = 13;
    localparam int ID_DIGIT_3 = 14;

    // Row-major, MSB is row 0 / column 0.
    typedef logic [24:0] glyph_bitmap_t;

    function automatic glyph_bitmap_t glyph_bitmap(input int unsigned id);
        case (id)
            ID_P:       return 25'b11110_10001_11110_10000_10000;
            ID_L:       return 25'b10000_10000_10000_10000_11110;
            ID_A:       return 25'b01110_10001_11111_10001_10001;
            ID_Y:       return 25'b10001_01010_00100_00100_00100;
            ID_E:       return 25'b11111_10000_11110_10000_11111;
            ID_V:       return 25'b10001_10001_10001_01010_00100;
            ID_W:       return 25'b10001_10001_10101_11011_10001;
            ID_H:       return 25'b10001_10001_11111_10001_10001;
            ID_C:       return 25'b01111_10000_10000_10000_01111;
            ID_M:       return 25'b10001_11011_10101_10001_10001;
            ID_O:       return 25'b01110_10001_10001_10001_01110;
            ID_DASH:    return 25'b00000_00000_11111_00000_00000;
            ID_DIGIT_1: return 25'b00100_01100_00100_00100_01110;
            ID_DIGIT_2: return 25'b11110_00001_01110_10000_11111;
            ID_DIGIT_3: return 25'b11110_00001_01110_00001_11110;
            default:    return '0;
        endcase
    endfunction

endpackage

// File: rtl/glyph_rom.sv
// glyph_rom: combinational lookup of one bitmap bit by glyph ID, row and column.
module glyph_rom
    import glyph_pkg::*;
#(
    parameter int ID_W = 6
) (
    input  logic [ID_W-1:0] i_id,
    input  logic [2:0]      i_row,
    input  logic [2:0]      i_col,
    output logic            o_bit
);
    glyph_bitmap_t w_bitmap;
    logic [4:0]    w_index;

    always_comb begin
        w_bitmap = glyph_bitmap(32'(i_id));
        w_index  = 5'd24 - (5'(i_row) * 5'd5 + 5'(i_col));
        o_bit    = 1'b0;
        if (i_row < 3'd5 && i_col < 3'd5) begin
            o_bit = w_bitmap[w_index];
        end
    end
endmodule

// File: rtl/glyph_line_renderer.sv
// glyph_line_renderer: one line of scaled 5x5 glyphs, 2-cycle pipeline from pix_en to pix_on.
// Optional cursor blink inversion is enabled by defining GLYPH_CURSOR_BLINK_EN.
module glyph_line_renderer
    import glyph_pkg::*;
#(
    parameter int NUM_CHARS = 8,
    parameter int SCALE     = 4,
    parameter int GAP_CELLS = 1,
    parameter int ID_W      = 6,
    parameter int BLANK_ID  = BLANK_ID_DEFAULT,
    parameter int X_W       = 10,
    parameter int Y_W       = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pix_en,
    input  logic [X_W-1:0]  x,
    input  logic [Y_W-1:0]  y,
    input  logic [X_W-1:0]  xstart,
    input  logic [Y_W-1:0]  ystart,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [ID_W-1:0] wr_id,
`ifdef GLYPH_CURSOR_BLINK_EN
    input  logic            cursor_en,
    input  logic [4:0]      cursor_pos,
`endif
    output logic            pix_on,
    output logic            pix_valid,
    output logic            busy
);
    localparam int SUB_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int CELL_W = $clog2(GLYPH_CELLS + GAP_CELLS);
    localparam int CHR_W  = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int ROW_W  = 3;

    localparam logic [SUB_W-1:0]  SUB_LAST    = SUB_W'(SCALE - 1);
    localparam logic [CELL_W-1:0] CELL_LAST   = CELL_W'(GLYPH_CELLS + GAP_CELLS - 1);
    localparam logic [CELL_W-1:0] GLYPH_LAST  = CELL_W'(GLYPH_CELLS - 1);
    localparam logic [CELL_W-1:0] CELL_LIMIT  = CELL_W'(GLYPH_CELLS);
    localparam logic [CHR_W-1:0]  CHR_LAST    = CHR_W'(NUM_CHARS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(GLYPH_CELLS - 1);
    localparam logic [5:0]        NUM_CHARS_6 = 6'(NUM_CHARS);
    localparam logic [ID_W-1:0]   BLANK       = ID_W'(BLANK_ID);

    logic [ID_W-1:0]   r_buf [NUM_CHARS];
    logic [X_W-1:0]    r_xs;
    logic [Y_W-1:0]    r_ys;
    logic [SUB_W-1:0]  r_vsub, r_hsub, w_vsub, w_hsub;
    logic [ROW_W-1:0]  r_vrow, w_vrow;
    logic [CELL_W-1:0] r_hcell, w_hcell;
    logic [CHR_W-1:0]  r_chr, w_chr;
    logic              r_vact, r_hact, w_vact, w_hact;
    logic [ID_W-1:0]   r_s0_id;
    logic              r_s0_valid, r_pix_on, r_pix_valid;
    logic              w_frame_start, w_in_cell, w_rom_bit, w_invert;
    logic [X_W-1:0]    w_xs;
    logic [Y_W-1:0]    w_ys;

    // The origin bypass lets the frame-start pixel already see the new shadow values.
    always_comb begin
        w_frame_start = pix_en && (x == '0) && (y == '0);
        w_xs          = w_frame_start ? xstart : r_xs;
        w_ys          = w_frame_start ? ystart : r_ys;
    end

    always_comb begin
        w_vsub = r_vsub;
        w_vrow = r_vrow;
        w_vact = r_vact;
        if (pix_en && (x == '0)) begin
            if (y == w_ys) begin
                w_vact = 1'b1;
                w_vrow = '0;
                w_vsub = '0;
            end else if (r_vact) begin
                if (r_vsub == SUB_LAST) begin
                    w_vsub = '0;
                    if (r_vrow == ROW_LAST) begin
                        w_vact = 1'b0;
                        w_vrow = '0;
                    end else begin
                        w_vrow = r_vrow + 1'b1;
                    end
                end else begin
                    w_vsub = r_vsub + 1'b1;
                end
            end
        end
    end

    // The last glyph has no trailing gap; the line ends after its fifth cell.
    always_comb begin
        w_hsub  = r_hsub;
        w_hcell = r_hcell;
        w_chr   = r_chr;
        w_hact  = r_hact;
        if (pix_en) begin
            if (x == w_xs || x == '0) begin
                w_hact  = (x == w_xs);
                w_hsub  = '0;
                w_hcell = '0;
                w_chr   = '0;
            end else if (r_hact) begin
                if (r_hsub != SUB_LAST) begin
                    w_hsub = r_hsub + 1'b1;
                end else begin
                    w_hsub = '0;
                    if (r_hcell == GLYPH_LAST && r_chr == CHR_LAST) begin
                        w_hact  = 1'b0;
                        w_hcell = '0;
                        w_chr   = '0;
                    end else if (r_hcell == CELL_LAST) begin
                        w_hcell = '0;
                        w_chr   = r_chr + 1'b1;
                    end else begin
                        w_hcell = r_hcell + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                r_buf[i] <= BLANK;
            end
        end else if (wr_en && ({1'b0, wr_addr} < NUM_CHARS_6)) begin
            r_buf[wr_addr[CHR_W-1:0]] <= wr_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xs       <= '0;
            r_ys       <= '0;
            r_vsub     <= '0;
            r_vrow     <= '0;
            r_vact     <= 1'b0;
            r_hsub     <= '0;
            r_hcell    <= '0;
            r_chr      <= '0;
            r_hact     <= 1'b0;
            r_s0_id    <= BLANK;
            r_s0_valid <= 1'b0;
        end else begin
            r_xs       <= w_xs;
            r_ys       <= w_ys;
            r_vsub     <= w_vsub;
            r_vrow     <= w_vrow;
            r_vact     <= w_vact;
            r_hsub     <= w_hsub;
            r_hcell    <= w_hcell;
            r_chr      <= w_chr;
            r_hact     <= w_hact;
            r_s0_id    <= r_buf[w_chr];
            r_s0_valid <= pix_en;
        end
    end

    glyph_rom #(.ID_W(ID_W)) u_rom (
        .i_id  (r_s0_id),
        .i_row (r_vrow),
        .i_col (r_hcell[2:0]),
        .o_bit (w_rom_bit)
    );

`ifdef GLYPH_CURSOR_BLINK_EN
    logic [4:0] r_frame_cnt;
    logic       r_started, r_blink_phase;

    // The first frame start only arms the counter so frames 0..31 share phase 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt   <= '0;
            r_started     <= 1'b0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_start) begin
            if (!r_started) begin
                r_started <= 1'b1;
            end else if (r_frame_cnt == 5'(BLINK_PERIOD - 1)) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_invert = cursor_en && r_blink_phase && (5'(r_chr) == cursor_pos);
`else
    assign w_invert = 1'b0;
`endif

    assign w_in_cell = r_hact && r_vact && (r_hcell < CELL_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pix_on    <= 1'b0;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= r_s0_valid;
            r_pix_on    <= r_s0_valid && w_in_cell &&
                           ((w_rom_bit && (r_s0_id != BLANK)) ^ w_invert);
        end
    end

    assign pix_on    = r_pix_on;
    assign pix_valid = r_pix_valid;
    assign busy      = r_hact && r_vact;
endmodule

// File: tb/tb_glyph_line_renderer.sv
// tb_glyph_line_renderer: directed raster frames against a geometric reference of the text line.
module tb_glyph_line_renderer;
    localparam int W       = 300;
    localparam int H       = 76;
    localparam int FULL_LO = 46;
    localparam int FULL_HI = 73;
    localparam int SHORT_W = 4;
    localparam int HBLANK  = 2;
    localparam int TB_ID_L    = 1;
    localparam int TB_ID_H    = 7;
    localparam int TB_ID_DASH = 11;
    localparam int BUSY_PER_FRAME = 20 * 188;

    logic       clk = 1'b0;
    logic       rst_n, pix_en, wr_en;
    logic [9:0] x, xstart;
    logic [8:0] y, ystart;
    logic [4:0] wr_addr;
    logic [5:0] wr_id;
    logic       pix_on, pix_valid, busy;
`ifdef GLYPH_CURSOR_BLINK_EN
    logic       cursor_en  = 1'b0;
    logic [4:0] cursor_pos = 5'd0;
`endif

    always #5 clk = ~clk;

    glyph_line_renderer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en    (pix_en),
        .x         (x),
        .y         (y),
        .xstart    (xstart),
        .ystart    (ystart),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_id     (wr_id),
`ifdef GLYPH_CURSOR_BLINK_EN
        .cursor_en (cursor_en),
        .cursor_pos(cursor_pos),
`endif
        .pix_on    (pix_on),
        .pix_valid (pix_valid),
        .busy      (busy)
    );

    int checkCount = 0;
    int errorCount = 0;
    logic [5:0] modelBuf [8];
    int  modelXs, modelYs;
    bit  modelActive = 0;
    bit  prevValid = 0, prevOn = 0;
    int  prevX = 0, prevY = 0;
    int  frameIdx = 0;
    int  frameOnErr, frameValErr, frameBusy, firstBadX, firstBadY;
    int  pixWrX = -1, pixWrY = -1, pixWrAddr = 0, pixWrId = 0;
    int  xsChangeY = -1, xsChangeVal = 0;
    int  rstX = -1, rstY = -1;
    int  tgtFrame [20], tgtX [20], tgtY [20], tgtVal [20];
    int  numTgt = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic addTarget(input int f, input int tx, input int ty, input int v);
        tgtFrame[numTgt] = f;
        tgtX[numTgt]     = tx;
        tgtY[numTgt]     = ty;
        tgtVal[numTgt]   = v;
        numTgt++;
    endtask

    function automatic logic [24:0] tbBitmap(input logic [5:0] id);
        case (int'(id))
            TB_ID_L:    return 25'b10000_10000_10000_10000_11110;
            TB_ID_H:    return 25'b10001_10001_11111_10001_10001;
            TB_ID_DASH: return 25'b00000_00000_11111_00000_00000;
            default:    return '0;
        endcase
    endfunction

    // Geometry: glyph pitch 24 px (20 px glyph + 4 px gap), 8 glyphs, 20 rows.
    function automatic logic modelPixel(input int px, input int py);
        int dx, dy, c, col, row;
        logic [24:0] bm;
        if (!modelActive) return 1'b0;
        dx = px - modelXs;
        dy = py - modelYs;
        if (dx < 0 || dy < 0 || dy >= 20) return 1'b0;
        c = dx / 24;
        if (c >= 8) return 1'b0;
        col = (dx % 24) / 4;
        if (col >= 5) return 1'b0;
        row = dy / 4;
        bm = tbBitmap(modelBuf[c]);
        return bm[24 - (row * 5 + col)];
    endfunction

    task automatic applyStimulus(input bit en, input int px, input int py, input bit doRst,
                                 input bit doWr, input int addr, input int id);
        bit curValid, curOn;
        rst_n   = !doRst;
        pix_en  = en;
        x       = 10'(px);
        y       = 9'(py);
        wr_en   = doWr;
        wr_addr = 5'(addr);
        wr_id   = 6'(id);
        curValid = 0;
        curOn    = 0;
        if (doRst) begin
            for (int i = 0; i < 8; i++) modelBuf[i] = 6'd63;
            modelXs = 0;
            modelYs = 0;
            modelActive = 0;
            prevValid = 0;
            prevOn = 0;
        end else begin
            if (en && px == 0 && py == 0) begin
                modelXs = int'(xstart);
                modelYs = int'(ystart);
                modelActive = 1;
            end
            curValid = en;
            curOn = en ? modelPixel(px, py) : 1'b0;
            if (doWr && addr < 8) modelBuf[addr] = 6'(id);
        end
        @(posedge clk);
        #1;
        if (pix_valid !== prevValid) frameValErr++;
        if (pix_on !== prevOn) begin
            if (frameOnErr == 0) begin
                firstBadX = prevX;
                firstBadY = prevY;
            end
            frameOnErr++;
        end
        if (busy === 1'b1) frameBusy++;
        for (int i = 0; i < numTgt; i++) begin
            if (prevValid && tgtFrame[i] == frameIdx && tgtX[i] == prevX && tgtY[i] == prevY)
                checkOutput($sformatf("f%0d px(%0d,%0d)", frameIdx, prevX, prevY), int'(pix_on), tgtVal[i]);
        end
        if (doRst) begin
            checkOutput("reset pix_on", int'(pix_on), 0);
            checkOutput("reset pix_valid", int'(pix_valid), 0);
            checkOutput("reset busy", int'(busy), 0);
        end
        prevValid = curValid;
        prevOn    = curOn;
        prevX     = px;
        prevY     = py;
    endtask

    task automatic runFrame(input bit checkBusy);
        frameOnErr = 0;
        frameValErr = 0;
        frameBusy = 0;
        firstBadX = -1;
        firstBadY = -1;
        for (int yy = 0; yy < H; yy++) begin
            int rowW;
            rowW = (yy >= FULL_LO && yy <= FULL_HI) ? W : SHORT_W;
            if (yy == xsChangeY) xstart = 10'(xsChangeVal);
            for (int xx = 0; xx < rowW; xx++) begin
                applyStimulus(1'b1, xx, yy, (xx == rstX && yy == rstY),
                              (xx == pixWrX && yy == pixWrY), pixWrAddr, pixWrId);
            end
            for (int b = 0; b < HBLANK; b++) applyStimulus(1'b0, 0, yy, 1'b0, 1'b0, 0, 0);
        end
        repeat (3) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
        checkOutput($sformatf("f%0d pix_on errors (first at %0d,%0d)", frameIdx, firstBadX, firstBadY),
                    frameOnErr, 0);
        checkOutput($sformatf("f%0d pix_valid errors", frameIdx), frameValErr, 0);
        if (checkBusy) checkOutput($sformatf("f%0d busy cycles", frameIdx), frameBusy, BUSY_PER_FRAME);
        frameIdx++;
        pixWrX = -1;
        pixWrY = -1;
        xsChangeY = -1;
        rstX = -1;
        rstY = -1;
    endtask

    initial begin
        rst_n = 1'b0; pix_en = 1'b0; x = '0; y = '0;
        xstart = 10'd100; ystart = 9'd50;
        wr_en = 1'b0; wr_addr = '0; wr_id = '0;
        for (int i = 0; i < 8; i++) modelBuf[i] = 6'd63;

        addTarget(3,  99, 50, 0); addTarget(3, 100, 50, 1); addTarget(3, 103, 50, 1);
        addTarget(3, 104, 50, 0); addTarget(3, 100, 69, 1); addTarget(3, 115, 66, 1);
        addTarget(3, 116, 66, 0); addTarget(3, 104, 60, 0); addTarget(3, 172, 50, 1);
        addTarget(3, 173, 50, 0);
        addTarget(4, 100, 65, 1); addTarget(4, 200, 66, 0); addTarget(4, 172, 50, 0);
        addTarget(5, 200, 50, 1); addTarget(5, 203, 69, 1); addTarget(5, 100, 50, 0);

        $display("[TB] reset and three blank frames");
        repeat (3) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
        repeat (3) runFrame(1'b1);

        $display("[TB] load buffer, out-of-range write ignored");
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 0, TB_ID_L);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 3, TB_ID_H);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 8, TB_ID_DASH);
        pixWrX = 172; pixWrY = 50; pixWrAddr = 3; pixWrId = TB_ID_DASH;
        runFrame(1'b1);

        $display("[TB] origin change mid-frame");
        xsChangeY = 60; xsChangeVal = 200;
        runFrame(1'b1);
        runFrame(1'b0);

        $display("[TB] reset mid-line");
        rstX = 110; rstY = 52;
        runFrame(1'b0);
        runFrame(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
